// File: rtl/cache_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_controller_pkg
// Description : Shared definitions for the 2-way set-associative cache
//               controller. Holds the FSM state encoding, the default index
//               and tag width constants and the per-line record.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_controller_pkg;

    localparam int c_OFFSET_W = 2;    // byte offset inside a 32-bit word
    localparam int c_INDEX_W  = 6;    // log2 of the default set count (64)
    localparam int c_TAG_W    = 10;   // default stored tag width
    localparam int c_STATE_W  = 2;

    // Controller FSM, explicitly encoded
    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_MISS = 2'd1,
        ST_WR_THRU = 2'd2
    } state_t;

    // One cache line as seen at a way's read port
    typedef struct packed {
        logic               valid;
        logic [c_TAG_W-1:0] tag;
        logic [31:0]        data;
    } line_t;

endpackage
`default_nettype wire

// File: rtl/cache_way_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_way_array
// Description : Storage for one way of the cache: a resettable valid bit per
//               set plus tag and data arrays (no reset needed), and the hit
//               compare for the addressed set.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               index, tag    - set index and tag of the current access
//               fill_en       - write valid/tag/data of the indexed set
//               upd_en        - write data only (store hit)
//               wr_data       - data written by fill_en or upd_en
//               hit           - indexed line valid and tag equal
//               line          - indexed line record
// Revision    : 1.0 - initial release
// ============================================================================
module cache_way_array
    import cache_controller_pkg::*;
#(
    parameter int SETS    = 64,
    parameter int INDEX_W = c_INDEX_W,
    parameter int TAG_W   = c_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   tag,
    input  logic               fill_en,
    input  logic               upd_en,
    input  logic [31:0]        wr_data,
    output logic               hit,
    output line_t              line
);

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (fill_en) begin
            r_valid[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            r_tag[index] <= tag;
        end
        if (fill_en || upd_en) begin
            r_data[index] <= wr_data;
        end
    end

    assign hit  = r_valid[index] && (r_tag[index] == tag);
    assign line = '{valid: r_valid[index],
                    tag:   c_TAG_W'(r_tag[index]),
                    data:  r_data[index]};

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : cache_controller
// Description : 2-way set-associative, write-through, no-write-allocate cache
//               with one 32-bit word per line and one LRU bit per set.
//               Read hits complete in the request cycle; read misses fetch
//               from SRAM and fill the victim way; stores always go through
//               to SRAM and update the cached copy only on a hit.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               address, wdata           - CPU word address and store data
//               rd_en, wr_en             - CPU load / store (held until ready)
//               rdata, ready             - load result / request complete
//               sram_addr, sram_wdata    - pass-through to SRAM controller
//               sram_rd_en, sram_wr_en   - SRAM requests (from state only)
//               sram_rdata, sram_ready   - SRAM read word / op complete
//               hit_cnt, miss_cnt        - saturating read statistics
// Config      : CACHE_STATS_EN - when defined, builds the hit/miss counters;
//               otherwise both counter outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int TAG_W = c_TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    localparam int c_IDX_W   = $clog2(SETS);
    localparam int c_TAG_LSB = c_OFFSET_W + c_IDX_W;

    logic [c_IDX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    state_t             r_state;
    state_t             w_next_state;
    logic [SETS-1:0]    r_lru;          // per set: way to evict next

    logic [1:0]  w_hit;
    line_t       w_line [2];
    logic [1:0]  w_fill;
    logic [1:0]  w_upd;
    logic [31:0] w_way_wdata;

    logic        w_wr_req;
    logic        w_rd_req;
    logic        w_hit_any;
    logic        w_hit_way;
    logic [31:0] w_hit_data;
    logic        w_victim;
    logic        w_lru_we;
    logic        w_lru_val;
    logic        w_rd_hit;
    logic        w_rd_miss_done;

    assign w_index    = address[c_OFFSET_W +: c_IDX_W];
    assign w_tag      = address[c_TAG_LSB +: TAG_W];
    assign sram_addr  = address;
    assign sram_wdata = wdata;

    // A simultaneous load and store is handled as a store
    assign w_wr_req = wr_en;
    assign w_rd_req = rd_en & ~wr_en;

    assign w_hit_any  = |w_hit;
    assign w_hit_way  = w_hit[1];
    assign w_hit_data = w_hit[1] ? w_line[1].data : w_line[0].data;

    // Empty ways are filled first (way 0 before way 1), then the LRU way
    assign w_victim = !w_line[0].valid ? 1'b0 :
                      !w_line[1].valid ? 1'b1 : r_lru[w_index];

    // Fills carry the SRAM word; store hits carry the CPU data
    assign w_way_wdata = (r_state == ST_RD_MISS) ? sram_rdata : wdata;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_way
            cache_way_array #(
                .SETS    (SETS),
                .INDEX_W (c_IDX_W),
                .TAG_W   (TAG_W)
            ) u_way (
                .clk     (clk),
                .rst     (rst),
                .index   (w_index),
                .tag     (w_tag),
                .fill_en (w_fill[g] & ~rst),
                .upd_en  (w_upd[g] & ~rst),
                .wr_data (w_way_wdata),
                .hit     (w_hit[g]),
                .line    (w_line[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lru <= '0;
        end else if (w_lru_we) begin
            r_lru[w_index] <= w_lru_val;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        ready          = 1'b0;
        rdata          = '0;
        sram_rd_en     = 1'b0;
        sram_wr_en     = 1'b0;
        w_fill         = '0;
        w_upd          = '0;
        w_lru_we       = 1'b0;
        w_lru_val      = 1'b0;
        w_rd_hit       = 1'b0;
        w_rd_miss_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_req) begin
                    w_next_state = ST_WR_THRU;
                end else if (w_rd_req) begin
                    if (w_hit_any) begin
                        ready     = 1'b1;
                        rdata     = w_hit_data;
                        w_lru_we  = 1'b1;
                        w_lru_val = ~w_hit_way;
                        w_rd_hit  = 1'b1;
                    end else begin
                        w_next_state = ST_RD_MISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            ST_RD_MISS: begin
                sram_rd_en = 1'b1;
                if (!w_rd_req) begin
                    // Load withdrawn: abandon without touching the arrays
                    w_next_state = ST_IDLE;
                end else if (sram_ready) begin
                    ready            = 1'b1;
                    rdata            = sram_rdata;
                    w_fill[w_victim] = 1'b1;
                    w_lru_we         = 1'b1;
                    w_lru_val        = ~w_victim;
                    w_rd_miss_done   = 1'b1;
                    w_next_state     = ST_IDLE;
                end
            end
            ST_WR_THRU: begin
                sram_wr_en = 1'b1;
                if (!w_wr_req) begin
                    w_next_state = ST_IDLE;
                end else if (sram_ready) begin
                    ready = 1'b1;
                    if (w_hit_any) begin
                        w_upd[w_hit_way] = 1'b1;
                        w_lru_we         = 1'b1;
                        w_lru_val        = ~w_hit_way;
                    end
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_rd_hit && (r_hit_cnt != 16'hFFFF)) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (w_rd_miss_done && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_rd_hit ^ w_rd_miss_done;
    assign hit_cnt        = '0;
    assign miss_cnt       = '0;
`endif

    // Address bits outside index/tag and the read-back tags are not consumed
    logic w_unused;
    assign w_unused = ^{address[31:c_TAG_LSB+TAG_W], address[c_OFFSET_W-1:0],
                        w_line[0].tag, w_line[1].tag};

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`timescale 1ns/1ps
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_rdata = '0;
    logic        sram_ready = 1'b0;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .wdata      (wdata),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rd_en (sram_rd_en),
        .sram_wr_en (sram_wr_en),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        hit;
        logic [31:0] addr;
        logic [31:0] data;
    } rexp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wexp_t;

    rexp_t rq[$];
    wexp_t wq[$];

    // Backing memory shared by the SRAM model and the expectations
    logic [31:0] mem [logic [31:0]];
    // Reference cache: per set, resident addresses ordered most-recent first
    logic [31:0] lines [64][$];
    int n_hit  = 0;
    int n_miss = 0;
    logic sram_hold = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 2) & 32'h3F);
    endfunction

    function automatic int find(input logic [31:0] a);
        int s = set_of(a);
        for (int i = 0; i < lines[s].size(); i++)
            if (lines[s][i] == a) return i;
        return -1;
    endfunction

    function automatic void touch(input logic [31:0] a, input int pos);
        int s = set_of(a);
        lines[s].delete(pos);
        lines[s].push_front(a);
    endfunction

    function automatic void insert(input logic [31:0] a);
        int s = set_of(a);
        lines[s].push_front(a);
        if (lines[s].size() > 2) void'(lines[s].pop_back());
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) lines[i].delete();
        n_hit  = 0;
        n_miss = 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // SRAM model: random 0..3 cycle latency, one-cycle ready pulse
    int s_cnt = 0;
    int s_lat = 0;
    always @(posedge clk) begin
        #1;
        if (!(sram_rd_en || sram_wr_en) || sram_hold) begin
            sram_ready = 1'b0;
            s_cnt      = 0;
            s_lat      = int'($urandom_range(0, 3));
        end else if (s_cnt == s_lat) begin
            sram_ready = 1'b1;
            sram_rdata = mem_rd(sram_addr);
        end else begin
            sram_ready = 1'b0;
            s_cnt++;
        end
    end

    // Monitor: pops expectations whenever the DUT completes a request
    rexp_t er;
    wexp_t ew;
    always @(negedge clk) begin
        if (!rst) begin
            if (sram_rd_en && sram_wr_en) begin
                errors++;
                $display("FAIL sram_excl: rd_en=%b wr_en=%b required not both 1", sram_rd_en, sram_wr_en);
            end
            if (rd_en && !wr_en && ready) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: ready=1 with no load expected");
                end else begin
                    er = rq.pop_front();
                    check("rd_hit", {31'b0, ~sram_rd_en}, {31'b0, er.hit});
                    check("rd_data", rdata, er.data);
                    if (!er.hit) check("rd_sram_addr", sram_addr, er.addr);
                end
            end
            if (wr_en && ready) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: ready=1 with no store expected");
                end else begin
                    ew = wq.pop_front();
                    check("wr_sram_en", {31'b0, sram_wr_en}, 32'd1);
                    check("wr_sram_addr", sram_addr, ew.addr);
                    check("wr_sram_wdata", sram_wdata, ew.data);
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ready && cyc < 50);
        if (!ready) begin
            checks++; errors++;
            $display("FAIL %s_timeout: ready=0 after %0d cycles, required 1", name, cyc);
        end
    endtask

    task automatic do_read(input logic [31:0] a);
        int pos;
        @(posedge clk); #1;
        address = a; rd_en = 1'b1; wr_en = 1'b0; wdata = $urandom;
        pos = find(a);
        rq.push_back('{hit: (pos >= 0), addr: a, data: mem_rd(a)});
        if (pos >= 0) begin touch(a, pos); n_hit++; end
        else begin insert(a); n_miss++; end
        wait_ready("rd");
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic both);
        int pos;
        @(posedge clk); #1;
        address = a; wdata = d; wr_en = 1'b1; rd_en = both;
        wq.push_back('{addr: a, data: d});
        mem[a] = d;
        pos = find(a);
        if (pos >= 0) touch(a, pos);
        wait_ready("wr");
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic check_counters();
`ifdef CACHE_STATS_EN
        check("hit_cnt", {16'b0, hit_cnt}, 32'(n_hit));
        check("miss_cnt", {16'b0, miss_cnt}, 32'(n_miss));
`else
        check("hit_cnt", {16'b0, hit_cnt}, 32'd0);
        check("miss_cnt", {16'b0, miss_cnt}, 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1; address = '0; wdata = '0; rd_en = 1'b0; wr_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_rdata", rdata, 32'd0);
        check("rst_sram_rd_en", {31'b0, sram_rd_en}, 32'd0);
        check("rst_sram_wr_en", {31'b0, sram_wr_en}, 32'd0);
        check_counters();

        // Reset while a miss is outstanding
        @(posedge clk); #1;
        address = 32'h0000_0C00; rd_en = 1'b1; sram_hold = 1'b1;
        @(negedge clk);
        check("miss_ready_low", {31'b0, ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("miss_sram_rd_en", {31'b0, sram_rd_en}, 32'd1);
        @(posedge clk); #1 rst = 1'b1; rd_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_sram_rd_en", {31'b0, sram_rd_en}, 32'd0);
        check("abort_ready", {31'b0, ready}, 32'd1);
        sram_hold = 1'b0;
        model_reset();

        // Cold miss, then three hits and another miss
        mem[32'h400] = 32'hDEAD_BEEF;
        do_read(32'h400);
        do_read(32'h400);
        do_read(32'h400);
        do_read(32'h400);
        do_read(32'h500);
        check_counters();

        // Third tag in set 0 evicts the LRU line
        do_read(32'h600);
        do_read(32'h400);
        do_read(32'h600);

        // Store hit updates the cached word
        do_write(32'h400, 32'h1122_3344, 1'b0);
        do_read(32'h400);

        // Store miss does not allocate
        do_write(32'h800, 32'hCAFE_F00D, 1'b0);
        do_read(32'h800);

        // Line aborted by reset was never filled
        do_read(32'h0000_0C00);

        // Load withdrawn mid-miss leaves the cache untouched
        @(posedge clk); #1;
        address = 32'h0000_0E00; rd_en = 1'b1; sram_hold = 1'b1;
        @(negedge clk);
        check("drop_ready_low", {31'b0, ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("drop_sram_rd_en", {31'b0, sram_rd_en}, 32'd1);
        @(posedge clk); #1 rd_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("drop_idle_rd_en", {31'b0, sram_rd_en}, 32'd0);
        sram_hold = 1'b0;
        do_read(32'h0000_0E00);

        // Randomised traffic over a few sets and tags
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int r;
            a = {14'b0, 10'($urandom_range(0, 3)), 6'($urandom_range(0, 2)), 2'b00};
            r = int'($urandom_range(0, 9));
            if (r < 6)      do_read(a);
            else if (r < 9) do_write(a, $urandom, 1'b0);
            else            do_write(a, $urandom, 1'b1);
        end
        check_counters();

        repeat (2) @(negedge clk);
        check("rq_drained", 32'(rq.size()), 32'd0);
        check("wq_drained", 32'(wq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
